// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: owns the frog's grid position, checks it against the cars in
// its lane every cycle, and keeps the lives/level registers. The level output
// feeds back into the car-motion block.
//
// state | meaning
// ------+-------------------------------------------------------------
// PLAY  | buttons move the frog, collision and goal checks active
// HIT   | frog frozen after a collision; respawn or game over
// WIN   | frog frozen on the goal row; level advances on exit
// OVER  | no lives left; only reset leaves this state
module frog_game_ctrl #(
    parameter logic [9:0]  BLOCKSIZE     = 10'd32,
    parameter logic [9:0]  X_OFFSET_LEFT = 10'd96,
    parameter logic [3:0]  NUM_COLS      = 4'd14,
    parameter logic [3:0]  START_COL     = 4'd7,
    parameter logic [1:0]  START_LIVES   = 2'd3,
    parameter logic [3:0]  MAX_LEVEL     = 4'd9,
    parameter logic [23:0] HOLD_CYCLES   = 24'd12_500_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic [9:0] lane0_car0_x_i,
    input  logic [9:0] lane1_car0_x_i,
    input  logic [9:0] lane2_car0_x_i,
    input  logic [9:0] lane3_car0_x_i,
    input  logic [9:0] lane4_car0_x_i,
    input  logic [9:0] lane5_car0_x_i,
    input  logic [9:0] lane4_car1_x_i,
    input  logic [9:0] lane0_length_i,
    input  logic [9:0] lane1_length_i,
    input  logic [9:0] lane2_length_i,
    input  logic [9:0] lane3_length_i,
    input  logic [9:0] lane4_length_i,
    input  logic [9:0] lane5_length_i,
    output logic [3:0] frog_col_o,
    output logic [2:0] frog_row_o,
    output logic [9:0] frog_x_o,
    output logic [1:0] lives_o,
    output logic [3:0] level_o,
    output logic       hit_o,
    output logic       level_up_o,
    output logic       game_over_o
);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HIT  = 2'd1,
        S_WIN  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [2:0] ROW_GOAL  = 3'd0;
    localparam logic [2:0] ROW_START = 3'd7;

    state_t      state_q;
    logic [3:0]  col_q;
    logic [2:0]  row_q;
    logic [1:0]  lives_q;
    logic [3:0]  level_q;
    logic [23:0] hold_cnt_q;
    logic        hit_q;
    logic        level_up_q;
    logic        game_over_q;
    logic [3:0]  btn_q;

    logic [3:0]  btn_now;
    logic [3:0]  btn_rise;
    logic [3:0]  col_d;
    logic [2:0]  row_d;
    logic        collide;

    // Bit order {up, down, left, right} so priority reads MSB-first.
    assign btn_now  = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
    assign btn_rise = btn_now & ~btn_q;

    assign frog_x_o = X_OFFSET_LEFT + BLOCKSIZE * {6'd0, col_q};

    // 11-bit compare keeps car_x + len from wrapping; a car re-entering at a
    // small x below the road offset is covered by the same rule.
    function automatic logic car_overlap(input logic [9:0] car_x,
                                         input logic [9:0] car_len,
                                         input logic [9:0] fx);
        logic [10:0] car_l;
        logic [10:0] car_r;
        logic [10:0] frog_l;
        logic [10:0] frog_r;
        car_l  = {1'b0, car_x};
        car_r  = car_l + {1'b0, car_len};
        frog_l = {1'b0, fx};
        frog_r = frog_l + {1'b0, BLOCKSIZE};
        return (car_l < frog_r) && (car_r > frog_l);
    endfunction

    // Overlap of the registered frog position with the cars of its lane.
    always_comb begin
        collide = 1'b0;
        case (row_q)
            3'd1: collide = car_overlap(lane0_car0_x_i, lane0_length_i, frog_x_o);
            3'd2: collide = car_overlap(lane1_car0_x_i, lane1_length_i, frog_x_o);
            3'd3: collide = car_overlap(lane2_car0_x_i, lane2_length_i, frog_x_o);
            3'd4: collide = car_overlap(lane3_car0_x_i, lane3_length_i, frog_x_o);
            3'd5: collide = car_overlap(lane4_car0_x_i, lane4_length_i, frog_x_o)
                          | car_overlap(lane4_car1_x_i, lane4_length_i, frog_x_o);
            3'd6: collide = car_overlap(lane5_car0_x_i, lane5_length_i, frog_x_o);
            default: collide = 1'b0;
        endcase
    end

    // One move per cycle; the highest-priority edge wins even if it is a
    // boundary no-op, and the others are dropped.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (btn_rise[3]) begin
            if (row_q != ROW_GOAL) row_d = row_q - 3'd1;
        end else if (btn_rise[2]) begin
            if (row_q != ROW_START) row_d = row_q + 3'd1;
        end else if (btn_rise[1]) begin
            if (col_q != 4'd0) col_d = col_q - 4'd1;
        end else if (btn_rise[0]) begin
            if (col_q < NUM_COLS - 4'd1) col_d = col_q + 4'd1;
        end
    end

    // Game FSM with registered position, score and pulse outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_PLAY;
            col_q       <= START_COL;
            row_q       <= ROW_START;
            lives_q     <= START_LIVES;
            level_q     <= 4'd1;
            hold_cnt_q  <= 24'd0;
            hit_q       <= 1'b0;
            level_up_q  <= 1'b0;
            game_over_q <= 1'b0;
            btn_q       <= 4'd0;
        end else begin
            // History tracks in every state so a held button never fires later.
            btn_q      <= btn_now;
            hit_q      <= 1'b0;
            level_up_q <= 1'b0;
            case (state_q)
                S_PLAY: begin
                    if (collide) begin
                        state_q    <= S_HIT;
                        lives_q    <= lives_q - 2'd1;
                        hit_q      <= 1'b1;
                        hold_cnt_q <= 24'd0;
                    end else if ((row_d == ROW_GOAL) && (row_q != ROW_GOAL)) begin
                        state_q    <= S_WIN;
                        row_q      <= row_d;
                        level_up_q <= 1'b1;
                        hold_cnt_q <= 24'd0;
                    end else begin
                        row_q <= row_d;
                        col_q <= col_d;
                    end
                end
                S_HIT: begin
                    if (lives_q == 2'd0) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                    end else if (hold_cnt_q == HOLD_CYCLES - 24'd1) begin
                        state_q    <= S_PLAY;
                        col_q      <= START_COL;
                        row_q      <= ROW_START;
                        hold_cnt_q <= 24'd0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 24'd1;
                    end
                end
                S_WIN: begin
                    if (hold_cnt_q == HOLD_CYCLES - 24'd1) begin
                        state_q    <= S_PLAY;
                        col_q      <= START_COL;
                        row_q      <= ROW_START;
                        hold_cnt_q <= 24'd0;
                        if (level_q < MAX_LEVEL) level_q <= level_q + 4'd1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 24'd1;
                    end
                end
                S_OVER: begin
                    game_over_q <= 1'b1;
                end
                default: begin
                    state_q <= S_PLAY;
                end
            endcase
        end
    end

    assign frog_col_o  = col_q;
    assign frog_row_o  = row_q;
    assign lives_o     = lives_q;
    assign level_o     = level_q;
    assign hit_o       = hit_q;
    assign level_up_o  = level_up_q;
    assign game_over_o = game_over_q;

endmodule
